hidden_backprop: RTL and testbench

HIDDEN_BACKPROP -- requirements
Module: hidden_backprop

---
 rtl/hidden_backprop.sv | 152 +++++++++++++++
 tb/tb_hidden_backprop.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hidden_backprop.sv
// Backward-pass weight update for one hidden neuron: four 8-bit input weights stepped by
// -(err * w_out) >>> LR_SHIFT. Optional macro HBP_SATURATE_EN clamps new weights to [-128, 127].
module hidden_backprop #(
  parameter int unsigned LR_SHIFT    = 6,
  parameter int unsigned W_INIT_HOLD = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        zero_weight_reset_i,
  input  logic [22:0] final_i,
  input  logic [3:0]  target_i,
  input  logic [7:0]  w_out_i,
  input  logic [9:0]  hidden_val_i,
  input  logic [3:0]  x_i,
  input  logic [31:0] w_i,
  output logic [31:0] weights_o,
  output logic        busy_o,
  output logic        b_end_o
);

  typedef enum logic [2:0] {StIdle, StErr, StMul, StUpd, StDone, StWaitLow} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic signed [23:0]       err_q, err_d;
  logic signed [31:0]       delta_q, delta_d;
  logic [3:0][7:0]          weights_q, weights_d;
  logic                     b_end_q, b_end_d;
  logic                     busy_q, busy_d;
  logic [22:0]              final_q, final_d;
  logic [3:0]               target_q, target_d;
  logic signed [7:0]        w_out_q, w_out_d;
  logic [9:0]               hidden_q, hidden_d;
  logic [3:0]               x_q, x_d;

  logic signed [7:0]        cur_w;
  logic signed [31:0]       step;
  logic signed [32:0]       diff;
  logic [7:0]               new_w;

  // Datapath for the weight currently selected by idx_q
  always_comb begin
    cur_w = weights_q[idx_q];
    step  = x_q[idx_q] ? (delta_q >>> LR_SHIFT) : 32'sd0;
    diff  = {{25{cur_w[7]}}, cur_w} - {step[31], step};
`ifdef HBP_SATURATE_EN
    if (diff > 33'sd127) begin
      new_w = 8'h7F;
    end else if (diff < -33'sd128) begin
      new_w = 8'h80;
    end else begin
      new_w = diff[7:0];
    end
`else
    new_w = diff[7:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    delta_d   = delta_q;
    weights_d = weights_q;
    b_end_d   = 1'b0;
    final_d   = final_q;
    target_d  = target_q;
    w_out_d   = w_out_q;
    hidden_d  = hidden_q;
    x_d       = x_q;

    if (zero_weight_reset_i) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      if (W_INIT_HOLD == 0) begin
        weights_d = w_i;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i) begin
            final_d  = final_i;
            target_d = target_i;
            w_out_d  = w_out_i;
            hidden_d = hidden_val_i;
            x_d      = x_i;
            state_d  = StErr;
          end
        end
        StErr: begin
          err_d   = {1'b0, final_q} - {20'd0, target_q};
          state_d = StMul;
        end
        StMul: begin
          // ReLU gate: a neuron that was inactive in the forward pass gets no gradient
          delta_d = (hidden_q == 10'd0) ? 32'sd0 : 32'(err_q) * 32'(w_out_q);
          idx_d   = 2'd0;
          state_d = StUpd;
        end
        StUpd: begin
          weights_d[idx_q] = new_w;
          idx_d            = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StDone;
            b_end_d = 1'b1;
          end
        end
        StDone:    state_d = StWaitLow;
        StWaitLow: if (!en_i) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle) && (state_d != StWaitLow);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      err_q     <= '0;
      delta_q   <= '0;
      weights_q <= w_i;
      b_end_q   <= 1'b0;
      busy_q    <= 1'b0;
      final_q   <= '0;
      target_q  <= '0;
      w_out_q   <= '0;
      hidden_q  <= '0;
      x_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      delta_q   <= delta_d;
      weights_q <= weights_d;
      b_end_q   <= b_end_d;
      busy_q    <= busy_d;
      final_q   <= final_d;
      target_q  <= target_d;
      w_out_q   <= w_out_d;
      hidden_q  <= hidden_d;
      x_q       <= x_d;
    end
  end

  assign weights_o = weights_q;
  assign busy_o    = busy_q;
  assign b_end_o   = b_end_q;

endmodule

// File: tb/tb_hidden_backprop.sv
// Directed bench for hidden_backprop: vector table of full updates plus hold, reload and reset
// sequences. Expected values follow HBP_SATURATE_EN when it is defined.
module tb_hidden_backprop;

  logic        clk = 1'b0;
  logic        rst_i, en_i, zwr_i;
  logic [22:0] final_i;
  logic [3:0]  target_i;
  logic [7:0]  w_out_i;
  logic [9:0]  hidden_i;
  logic [3:0]  x_i;
  logic [31:0] w_i;
  logic [31:0] weights_o;
  logic        busy_o, b_end_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hidden_backprop dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .en_i                (en_i),
    .zero_weight_reset_i (zwr_i),
    .final_i             (final_i),
    .target_i            (target_i),
    .w_out_i             (w_out_i),
    .hidden_val_i        (hidden_i),
    .x_i                 (x_i),
    .w_i                 (w_i),
    .weights_o           (weights_o),
    .busy_o              (busy_o),
    .b_end_o             (b_end_o)
  );

  typedef struct {
    string       name;
    logic [31:0] w;
    logic [22:0] fin;
    logic [3:0]  tgt;
    logic [7:0]  wout;
    logic [9:0]  hid;
    logic [3:0]  x;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    w_i      = v.w;
    final_i  = v.fin;
    target_i = v.tgt;
    w_out_i  = v.wout;
    hidden_i = v.hid;
    x_i      = v.x;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Pulse en_i once, scramble the operands afterwards, and watch for b_end_o.
  task automatic run_update(input string name, output int first_c, output int pulses);
    first_c = -1;
    pulses  = 0;
    en_i = 1'b1;
    tick();
    check({name, " busy"}, {31'd0, busy_o}, 32'd1);
    en_i     = 1'b0;
    final_i  = 23'h5A5A5;
    target_i = 4'hF;
    w_out_i  = 8'h81;
    x_i      = ~x_i;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (b_end_o) begin
        pulses++;
        if (first_c < 0) first_c = c;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (b_end_o) pulses++;
    end
  endtask

  initial begin
    int fc, np;
    vecs[0] = '{"basic", 32'h01020304, 23'd10, 4'd2, 8'd8, 10'd5, 4'b1111, 32'h00010203};
    vecs[1] = '{"x0101", 32'h01020304, 23'd10, 4'd2, 8'd8, 10'd5, 4'b0101, 32'h01010303};
    vecs[2] = '{"relu0", 32'h01020304, 23'd10, 4'd2, 8'd8, 10'd0, 4'b1111, 32'h01020304};
`ifdef HBP_SATURATE_EN
    vecs[3] = '{"bigneg", 32'h0, 23'h7FFFFF, 4'd0, 8'd127, 10'd1, 4'b0001, 32'h00000080};
    vecs[4] = '{"negerr", 32'h7F000010, 23'd1, 4'd9, 8'd8, 10'd3, 4'b1111, 32'h7F010111};
`else
    vecs[3] = '{"bigneg", 32'h0, 23'h7FFFFF, 4'd0, 8'd127, 10'd1, 4'b0001, 32'h00000002};
    vecs[4] = '{"negerr", 32'h7F000010, 23'd1, 4'd9, 8'd8, 10'd3, 4'b1111, 32'h80010111};
`endif
    // -288 >>> 6 rounds toward minus infinity: step -5
    vecs[5] = '{"negwout", 32'h10203040, 23'd100, 4'd4, 8'hFD, 10'd7, 4'b1010, 32'h15203540};

    rst_i = 1'b1; en_i = 1'b0; zwr_i = 1'b0;
    load(vecs[0]);
    do_reset();
    check("reset weights", weights_o, 32'h01020304);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset b_end", {31'd0, b_end_o}, 32'd0);

    foreach (vecs[i]) begin
      load(vecs[i]);
      do_reset();
      run_update(vecs[i].name, fc, np);
      check({vecs[i].name, " pulse cycle"}, fc, 6);
      check({vecs[i].name, " pulse count"}, np, 1);
      check({vecs[i].name, " weights"}, weights_o, vecs[i].exp_w);
    end

    // en_i held high: one update, then a low cycle re-arms for a second one
    load(vecs[0]);
    do_reset();
    en_i = 1'b1;
    count_pulses(20, np);
    check("hold pulses", np, 1);
    check("hold weights", weights_o, 32'h00010203);
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    count_pulses(12, np);
    en_i = 1'b0;
    check("rearm pulses", np, 1);
    check("rearm weights", weights_o, 32'hFF000102);

    // Reload mid-update after weight 0 changed
    load(vecs[0]);
    do_reset();
    en_i = 1'b1;
    tick();
    en_i = 1'b0;
    tick(); tick(); tick();
    check("zwr partial", weights_o, 32'h01020303);
    w_i   = 32'hAABBCCDD;
    zwr_i = 1'b1;
    tick();
    zwr_i = 1'b0;
    check("zwr weights", weights_o, 32'hAABBCCDD);
    check("zwr busy", {31'd0, busy_o}, 32'd0);
    check("zwr b_end", {31'd0, b_end_o}, 32'd0);
    count_pulses(10, np);
    check("zwr no pulse", np, 0);
    check("zwr hold", weights_o, 32'hAABBCCDD);

    // Reset while in MUL, then a clean update
    load(vecs[0]);
    do_reset();
    en_i = 1'b1;
    tick();
    en_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rstmul weights", weights_o, 32'h01020304);
    check("rstmul busy", {31'd0, busy_o}, 32'd0);
    check("rstmul b_end", {31'd0, b_end_o}, 32'd0);
    count_pulses(10, np);
    check("rstmul no pulse", np, 0);
    load(vecs[0]);
    run_update("after rst", fc, np);
    check("after rst pulse cycle", fc, 6);
    check("after rst weights", weights_o, 32'h00010203);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
